// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stage indices, bus width,
// FSM state encoding and the default exception vector.
package pipe_ctrl_pkg;

   localparam int unsigned STAGE_PC    = 0;
   localparam int unsigned STAGE_IFID  = 1;
   localparam int unsigned STAGE_IDEX  = 2;
   localparam int unsigned STAGE_EXMEM = 3;
   localparam int unsigned STAGE_MEMWB = 4;
   localparam int unsigned STAGE_WB    = 5;

   localparam int unsigned STALL_BUS_W = 6;
   typedef logic [STALL_BUS_W-1:0] stall_bus_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_e;

   localparam logic [31:0] EXC_VEC_DEF = 32'hBFC0_0380;

endpackage

// File: rtl/pipe_ctrl_int_sync.sv
// Two-flop synchroniser for asynchronous interrupt lines; output is the
// second flop, so a rising input is visible two edges later.
module int_sync #(
   parameter int unsigned W = 6
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage-tagged stall requests, sequences exception
// and interrupt flush/redirect, and counts PC-stall cycles.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned       STAGES    = STALL_BUS_W,
   parameter int unsigned       NREQ      = 4,
   parameter logic [NREQ*3-1:0] REQ_STAGE = {3'd3, 3'd2, 3'd2, 3'd1},
   parameter logic [31:0]       EXC_VEC   = EXC_VEC_DEF,
   parameter int unsigned       CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   stallreq,
   input  logic              flush_req,
   input  logic [31:0]       flush_pc,
   input  logic [5:0]        int_in,
   input  logic [5:0]        int_mask,
   input  logic              int_en,
   output logic [STAGES-1:0] stall,
   output logic [STAGES-1:0] flush,
   output logic              redirect_valid,
   output logic [31:0]       redirect_pc,
   output logic              int_ack,
   output logic [5:0]        int_cause,
   output logic [CNT_W-1:0]  stall_cycles
);

   // WB is the only latch allowed to retire during an exception flush.
   localparam logic [STAGES-1:0] FLUSH_ALL = {1'b0, {(STAGES-1){1'b1}}};
   localparam logic [STAGES-1:0] FLUSH_PC  = {{(STAGES-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [31:0]       tgt_q, tgt_d;
   logic              by_int_q, by_int_d;
   logic [5:0]        cause_q, cause_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [5:0]        int_sync_w;
   logic              any_req;
   logic [2:0]        smax;
   logic [STAGES-1:0] stall_merge;
   logic [STAGES-1:0] stall_v;
   logic [STAGES-1:0] flush_v;
   logic              take_int;

   int_sync #(.W(6)) u_int_sync (
      .clk_i  (clk),
      .rst_ni (rst),
      .d_i    (int_in),
      .q_o    (int_sync_w)
   );

   always_comb begin
      any_req = 1'b0;
      smax    = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (stallreq[i] && (!any_req || (REQ_STAGE[3*i +: 3] > smax))) begin
            smax    = REQ_STAGE[3*i +: 3];
            any_req = 1'b1;
         end
      end
      stall_merge = '0;
      for (int k = 0; k < int'(STAGES); k++) begin
         stall_merge[k] = any_req && (k <= int'(smax));
      end
   end

   assign take_int = int_en && (|(int_sync_w & int_mask)) && (stallreq == '0) && !flush_req;

   always_comb begin
      state_d  = state_q;
      tgt_d    = tgt_q;
      by_int_d = by_int_q;
      cause_d  = cause_q;
      flush_v  = '0;
      case (state_q)
         ST_IDLE: begin
            if (flush_req) begin
               tgt_d    = flush_pc;
               by_int_d = 1'b0;
               state_d  = ST_FLUSH;
            end else if (take_int) begin
               tgt_d    = EXC_VEC;
               by_int_d = 1'b1;
               cause_d  = int_sync_w & int_mask;
               state_d  = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            flush_v = FLUSH_ALL;
            state_d = ST_REDIRECT;
            if (flush_req) begin
               tgt_d    = flush_pc;
               by_int_d = 1'b0;
               state_d  = ST_FLUSH;
            end
         end
         ST_REDIRECT: begin
            flush_v = FLUSH_PC;
            state_d = ST_IDLE;
            if (flush_req) begin
               tgt_d    = flush_pc;
               by_int_d = 1'b0;
               state_d  = ST_FLUSH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Flush always wins over stall; reset forces the combinational stall bus low.
   assign stall_v = (state_q == ST_FLUSH) ? '0 : (stall_merge & ~flush_v);

   assign cnt_d = (stall_v[0] && (cnt_q != '1)) ? (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         tgt_q    <= '0;
         by_int_q <= 1'b0;
         cause_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         by_int_q <= by_int_d;
         cause_q  <= cause_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stall          = rst ? stall_v : '0;
   assign flush          = flush_v;
   assign redirect_valid = (state_q == ST_FLUSH);
   assign redirect_pc    = (state_q == ST_FLUSH) ? tgt_q : '0;
   assign int_ack        = (state_q == ST_FLUSH) && by_int_q;
   assign int_cause      = cause_q;
   assign stall_cycles   = cnt_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the five-stage MIPS core, replacing the fixed two-source stall controller. Merges any number of stage-tagged stall requests into the per-stage stall vector, and runs a flush/redirect state machine for synchronous exceptions. It also synchronises and arbitrates the six external interrupt lines and keeps a saturating stall-cycle counter. Sits beside IF/ID/EX/MEM/WB in the core top and drives the shared stall bus plus a new flush bus and PC-redirect port into IF.

## Interface
- STAGES, 6, stall/flush bus width; bit 0 = PC, bits 1..5 = IF/ID, ID/EX, EX/MEM, MEM/WB, WB latches
- NREQ, 4, number of stall request sources
- REQ_STAGE, {3'd3,3'd2,3'd2,3'd1}, packed NREQ×3 bits; field i = highest stage index frozen by source i
- EXC_VEC, 32'hBFC0_0380, interrupt redirect target
- CNT_W, 32, stall counter width
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset (one clock; async active-low is fixed)
- stallreq  in  NREQ  per-source stall request, level, combinational from stages
- flush_req  in  1  synchronous exception from MEM, single-cycle pulse
- flush_pc  in  32  exception handler target, valid with flush_req
- int_in  in  6  raw asynchronous interrupt lines
- int_mask  in  6  per-line enable (CP0 IM)
- int_en  in  1  global interrupt enable (CP0 IE & ~EXL)
- stall  out  STAGES  stall vector, bit k = hold latch k
- flush  out  STAGES  flush vector, bit k = clear latch k to bubble
- redirect_valid  out  1  IF must load redirect_pc next edge
- redirect_pc  out  32  redirect target
- int_ack  out  1  one-cycle pulse, interrupt taken
- int_cause  out  6  pending-and-masked lines captured at int_ack
- stall_cycles  out  CNT_W  saturating count of cycles with stall[0]=1

## Operation
- Stall merge (combinational): s_max = max REQ_STAGE[i] over asserted stallreq[i]; stall[k]=1 for k ≤ s_max, else 0; no request → all 0. Bubble enters latch s_max+1 implicitly, as now.
- FSM states IDLE, FLUSH, REDIRECT.
- IDLE: flush_req → latch flush_pc, go FLUSH. Else if take_int → latch EXC_VEC, capture int_cause, go FLUSH.
- take_int = int_en & |(int_sync & int_mask) & stallreq==0 & ~flush_req.
- FLUSH (1 cycle): flush[k]=1 for k ≤ STAGES-2 (WB retires); stall forced to 0; int_ack=1 if entered via interrupt; redirect_valid=1, redirect_pc=latched target; go REDIRECT.
- REDIRECT (1 cycle): flush[0]=1 only (squash wrong-path fetch); go IDLE.
- flush_req in FLUSH or REDIRECT: relatch target, go/stay FLUSH (newest exception wins).
- Interrupt sync: 2-flop synchroniser per line; int_sync = second flop; level-sensitive, not latched — source holds line until serviced.
- stall_cycles: +1 each cycle stall[0]=1, saturates at all-ones, never wraps.
- Flush overrides stall in every state; flush_req beats interrupt in the same cycle.

## Timing
- Reset (rst=0, async): FSM=IDLE, stall=0, flush=0, redirect_valid=0, redirect_pc=0, int_ack=0, int_cause=0, stall_cycles=0, synchronisers=0. Outputs valid from first edge after release.
- stall: zero latency from stallreq.
- flush_req sampled at edge t → flush, redirect_valid at cycle t+1 → flush[0] only at t+2 → IDLE at t+3.
- int_in rising → int_sync high 2 edges later → FLUSH next edge if take_int.
- int_ack, redirect_valid: exactly one cycle per event.
- rst asserted mid-FLUSH: all outputs to reset values immediately, pending redirect dropped.

## Structure
- Shared package: STAGE_PC..STAGE_WB indices, StallBus width, FSM state enum, EXC_VEC default.
- One sub-module: int_sync (2-flop synchroniser, width parameter).

## Test plan
- stallreq=4'b0010 (source 1, stage 2) → stall=6'b000111, flush=0; stall_cycles increments by 1 per cycle.
- stallreq=4'b1001 → stall=6'b001111 (max stage 3 wins).
- flush_req=1, flush_pc=32'h8000_0180 at edge t → t+1: flush=6'b011111, redirect_valid=1, redirect_pc=32'h8000_0180; t+2: flush=6'b000001; t+3: all 0.
- int_in=6'b000100, mask=6'b111111, int_en=1, no stalls → int_ack 3 cycles after assertion, int_cause=6'b000100, redirect_pc=EXC_VEC; with int_en=0 → never acked.
- flush_req and pending interrupt same cycle → redirect_pc=flush_pc, int_ack=0; interrupt taken later once back in IDLE.
- rst low during FLUSH → all outputs 0 asynchronously; CNT_W=4 with 20 stall cycles → stall_cycles=4'hF.
